// File: rtl/div_pkg.sv
// Shared types and constants for the multi-cycle signed divider.
package div_pkg;

   localparam int DIV_WIDTH = 32;
   localparam int DIV_STEPS = 32;

   localparam logic [DIV_WIDTH-1:0] DIV_ZERO_Q = '1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } div_state_t;

endpackage

// File: rtl/nr_div_step.sv
// One non-restoring division step: shift {A,Q} left, then add or subtract M.
module nr_div_step
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic [WIDTH:0]   a,
   input  logic [WIDTH-1:0] q,
   input  logic [WIDTH-1:0] m,
   output logic [WIDTH:0]   a_next,
   output logic [WIDTH-1:0] q_next
);

   logic [WIDTH:0] a_sh;
   logic [WIDTH:0] m_ext;

   always_comb begin
      a_sh   = {a[WIDTH-1:0], q[WIDTH-1]};
      m_ext  = {1'b0, m};
      // Sign of the old partial remainder picks subtract or add-back
      a_next = a[WIDTH] ? (a_sh + m_ext) : (a_sh - m_ext);
      q_next = {q[WIDTH-2:0], ~a_next[WIDTH]};
   end

endmodule

// File: rtl/divider_unit.sv
// Multi-cycle 32-bit signed divider: 32 non-restoring steps plus a fix-up cycle.
module divider_unit
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic             clock,
   input  logic             clear,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int CW = $clog2(DIV_STEPS);
   localparam logic [CW-1:0] LAST = CW'(DIV_STEPS - 1);

   div_state_t state;

   logic [WIDTH:0]   a;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] m;
   logic [CW-1:0]    count;
   logic             sign_q;
   logic             sign_r;

   logic [WIDTH:0]   a_next;
   logic [WIDTH-1:0] q_next;
   logic [WIDTH-1:0] dvd_mag;
   logic [WIDTH-1:0] dvs_mag;
   logic [WIDTH-1:0] rem_mag;
   logic [WIDTH-1:0] q_res;
   logic [WIDTH-1:0] r_res;

   nr_div_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .a      (a),
      .q      (q),
      .m      (m),
      .a_next (a_next),
      .q_next (q_next)
   );

   always_comb begin
      dvd_mag = dividend[WIDTH-1] ? -dividend : dividend;
      dvs_mag = divisor[WIDTH-1] ? -divisor : divisor;
      // Low bits of A+M are exact modulo 2^WIDTH
      rem_mag = a[WIDTH] ? (a[WIDTH-1:0] + m) : a[WIDTH-1:0];
      q_res   = sign_q ? -q : q;
      r_res   = sign_r ? -rem_mag : rem_mag;
   end

   always_ff @(posedge clock) begin
      if (clear) begin
         state       <= IDLE;
         busy        <= 1'b0;
         done        <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
         count       <= '0;
         a           <= '0;
         q           <= '0;
         m           <= '0;
         sign_q      <= 1'b0;
         sign_r      <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  if (divisor == '0) begin
                     quotient    <= WIDTH'(DIV_ZERO_Q);
                     remainder   <= dividend;
                     div_by_zero <= 1'b1;
                     done        <= 1'b1;
                     state       <= DONE;
                  end else begin
                     q           <= dvd_mag;
                     m           <= dvs_mag;
                     sign_r      <= dividend[WIDTH-1];
                     sign_q      <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                     a           <= '0;
                     count       <= '0;
                     busy        <= 1'b1;
                     div_by_zero <= 1'b0;
                     state       <= RUN;
                  end
               end
            end
            RUN: begin
               a     <= a_next;
               q     <= q_next;
               count <= count + 1'b1;
               if (count == LAST) begin
                  state <= FIX;
               end
            end
            FIX: begin
               quotient  <= q_res;
               remainder <= r_res;
               busy      <= 1'b0;
               done      <= 1'b1;
               state     <= DONE;
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
